// File: rtl/alu_pkg.sv
// Shared definitions for the execute stage: ALU opcodes and flag bit positions.
package alu_pkg;

    // 4-bit ALU opcode; values 13..15 are unused and produce a zero result.
    typedef enum logic [3:0] {
        ALU_PASS_A = 4'd0,
        ALU_ADD    = 4'd1,
        ALU_SUB    = 4'd2,
        ALU_AND    = 4'd3,
        ALU_OR     = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_NOT    = 4'd6,
        ALU_SHL    = 4'd7,
        ALU_SHR    = 4'd8,
        ALU_SAR    = 4'd9,
        ALU_INC    = 4'd10,
        ALU_DEC    = 4'd11,
        ALU_PASS_B = 4'd12
    } alu_op_e;

    // Bit positions inside the registered flag vector.
    localparam int unsigned FLAG_CARRY = 0;
    localparam int unsigned FLAG_ZERO  = 1;
    localparam int unsigned FLAG_NEG   = 2;
    localparam int unsigned NUM_FLAGS  = 3;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU.
//   a, b   : operands (b also supplies the shift amount in its low bits)
//   op     : opcode (alu_op_e encoding)
//   result : op result, modulo 2^WIDTH
//   carry  : carry-out / borrow / last bit shifted out, 0 otherwise
//   zero   : result == 0
//   neg    : result MSB
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             neg
);

    localparam int unsigned SAW = $clog2(WIDTH);
    localparam int unsigned XW  = WIDTH + 1;

    logic [SAW-1:0] sa;
    logic [XW-1:0]  sum_ext;
    logic [XW-1:0]  diff_ext;
    logic [XW-1:0]  inc_ext;
    logic [XW-1:0]  dec_ext;
    logic [XW-1:0]  shl_ext;
    logic [XW-1:0]  shr_ext;
    logic [XW-1:0]  sar_ext;

    assign sa = b[SAW-1:0];

    // One extra bit on each arithmetic/shift path captures carry, borrow or
    // the last bit shifted out; for shifts by 0 that extra bit stays 0.
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};
    assign inc_ext  = {1'b0, a} + XW'(1);
    assign dec_ext  = {1'b0, a} - XW'(1);
    assign shl_ext  = {1'b0, a} << sa;
    assign shr_ext  = {a, 1'b0} >> sa;
    assign sar_ext  = $signed({a, 1'b0}) >>> sa;

    // Opcode decode
    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            ALU_PASS_A: result = a;
            ALU_ADD:    {carry, result} = sum_ext;
            ALU_SUB:    {carry, result} = diff_ext;
            ALU_AND:    result = a & b;
            ALU_OR:     result = a | b;
            ALU_XOR:    result = a ^ b;
            ALU_NOT:    result = ~a;
            ALU_SHL:    {carry, result} = shl_ext;
            ALU_SHR:    {result, carry} = shr_ext;
            ALU_SAR:    {result, carry} = sar_ext;
            ALU_INC:    {carry, result} = inc_ext;
            ALU_DEC:    {carry, result} = dec_ext;
            ALU_PASS_B: result = b;
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
        zero = (result == '0);
        neg  = result[WIDTH-1];
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: operand-B mux, ALU, registered flags and a DEPTH-entry
// result history (entry 0 newest) feeding write-back and forwarding.
//   clk, rst_n         : posedge clock, async active-low reset
//   in_valid           : operation presented this cycle
//   stall / flush      : hold all state / drop incoming op and clear valids
//   register_content1  : operand A
//   register_content2  : operand B when alu_src_signal = 0
//   immediate_value    : sign-extended operand B when alu_src_signal = 1
//   alu_control_signal : opcode
//   flag_en            : accepted op updates the flags
//   res_data/res_valid : history entries, entry k at [k*WIDTH +: WIDTH]
//   carry_q/zero_q/neg_q : registered flags
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned IMM_WIDTH = 8,
    parameter int unsigned DEPTH     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       register_content1,
    input  logic [WIDTH-1:0]       register_content2,
    input  logic [IMM_WIDTH-1:0]   immediate_value,
    input  logic                   alu_src_signal,
    input  logic [3:0]             alu_control_signal,
    input  logic                   flag_en,
    output logic [DEPTH*WIDTH-1:0] res_data,
    output logic [DEPTH-1:0]       res_valid,
    output logic                   carry_q,
    output logic                   zero_q,
    output logic                   neg_q
);

    logic [WIDTH-1:0]     operand_b;
    logic [WIDTH-1:0]     alu_result;
    logic                 alu_carry;
    logic                 alu_zero;
    logic                 alu_neg;
    logic                 accept;
    logic [NUM_FLAGS-1:0] flags_q;
    logic [WIDTH-1:0]     hist_data  [DEPTH];
    logic                 hist_valid [DEPTH];

    assign operand_b = alu_src_signal ? WIDTH'($signed(immediate_value)) : register_content2;
    assign accept    = in_valid & ~stall & ~flush;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .a      (register_content1),
        .b      (operand_b),
        .op     (alu_control_signal),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero),
        .neg    (alu_neg)
    );

    // Flags load only from accepted ops with flag_en set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (accept && flag_en) begin
            flags_q[FLAG_CARRY] <= alu_carry;
            flags_q[FLAG_ZERO]  <= alu_zero;
            flags_q[FLAG_NEG]   <= alu_neg;
        end
    end

    assign carry_q = flags_q[FLAG_CARRY];
    assign zero_q  = flags_q[FLAG_ZERO];
    assign neg_q   = flags_q[FLAG_NEG];

    // History shift register; flush clears valids but leaves data in place
    for (genvar k = 0; k < DEPTH; k++) begin : g_hist
        if (k == 0) begin : g_head
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hist_data[0]  <= '0;
                    hist_valid[0] <= 1'b0;
                end else if (flush) begin
                    hist_valid[0] <= 1'b0;
                end else if (!stall) begin
                    hist_data[0]  <= alu_result;
                    hist_valid[0] <= in_valid;
                end
            end
        end else begin : g_tail
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hist_data[k]  <= '0;
                    hist_valid[k] <= 1'b0;
                end else if (flush) begin
                    hist_valid[k] <= 1'b0;
                end else if (!stall) begin
                    hist_data[k]  <= hist_data[k-1];
                    hist_valid[k] <= hist_valid[k-1];
                end
            end
        end

        assign res_data[k*WIDTH +: WIDTH] = hist_data[k];
        assign res_valid[k]               = hist_valid[k];
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with WIDTH=16, IMM_WIDTH=8, DEPTH=2.
module tb_alu_exec_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic [15:0] register_content1;
    logic [15:0] register_content2;
    logic [7:0]  immediate_value;
    logic        alu_src_signal;
    logic [3:0]  alu_control_signal;
    logic        flag_en;
    logic [31:0] res_data;
    logic [1:0]  res_valid;
    logic        carry_q;
    logic        zero_q;
    logic        neg_q;

    int tests_run    = 0;
    int tests_failed = 0;

    // Full observation {entry1, entry0, valid[1:0], carry, zero, neg}
    logic [36:0] obs;
    // Newest-entry observation {entry0, valid[0], carry, zero, neg}
    logic [19:0] obs0;
    assign obs  = {res_data, res_valid, carry_q, zero_q, neg_q};
    assign obs0 = {res_data[15:0], res_valid[0], carry_q, zero_q, neg_q};

    alu_exec_stage #(
        .WIDTH     (16),
        .IMM_WIDTH (8),
        .DEPTH     (2)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_valid           (in_valid),
        .stall              (stall),
        .flush              (flush),
        .register_content1  (register_content1),
        .register_content2  (register_content2),
        .immediate_value    (immediate_value),
        .alu_src_signal     (alu_src_signal),
        .alu_control_signal (alu_control_signal),
        .flag_en            (flag_en),
        .res_data           (res_data),
        .res_valid          (res_valid),
        .carry_q            (carry_q),
        .zero_q             (zero_q),
        .neg_q              (neg_q)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic fe, input logic v);
        alu_control_signal = op;
        register_content1  = a;
        register_content2  = b;
        alu_src_signal     = 1'b0;
        immediate_value    = 8'h00;
        flag_en            = fe;
        in_valid           = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive_op(ALU_PASS_A, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step();
        step();
        tests_run++;
        if (obs !== 37'h0) begin
            tests_failed++;
            $display("FAIL reset_state got %h want %h", obs, 37'h0);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        drive_op(ALU_ADD, 16'hFFFF, 16'h0001, 1'b1, 1'b1);
        step();
        tests_run++;
        if (obs !== {16'h0000, 16'h0000, 2'b01, 3'b110}) begin
            tests_failed++;
            $display("FAIL add_wrap got %h want %h", obs, {16'h0000, 16'h0000, 2'b01, 3'b110});
        end
        drive_op(ALU_ADD, 16'h1000, 16'h0234, 1'b0, 1'b1);
        step();
        tests_run++;
        if (obs !== {16'h0000, 16'h1234, 2'b11, 3'b110}) begin
            tests_failed++;
            $display("FAIL add_second got %h want %h", obs, {16'h0000, 16'h1234, 2'b11, 3'b110});
        end
        drive_op(ALU_PASS_A, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step();
        tests_run++;
        if ({res_data[31:16], res_valid, carry_q, zero_q, neg_q} !== {16'h1234, 2'b10, 3'b110}) begin
            tests_failed++;
            $display("FAIL add_entry1 got %h want %h",
                     {res_data[31:16], res_valid, carry_q, zero_q, neg_q}, {16'h1234, 2'b10, 3'b110});
        end
    endtask

    task automatic test_immediate();
        drive_op(ALU_SUB, 16'h0005, 16'h0100, 1'b1, 1'b1);
        alu_src_signal  = 1'b1;
        immediate_value = 8'hFE;
        step();
        tests_run++;
        if (obs0 !== {16'h0007, 1'b1, 3'b100}) begin
            tests_failed++;
            $display("FAIL imm_sub got %h want %h", obs0, {16'h0007, 1'b1, 3'b100});
        end
    endtask

    task automatic test_shifts();
        logic [3:0]  s_op  [4] = '{ALU_SHL, ALU_SAR, ALU_SHR, ALU_SHR};
        logic [15:0] s_a   [4] = '{16'h8001, 16'h8000, 16'h1234, 16'h0003};
        logic [15:0] s_b   [4] = '{16'h0001, 16'h000F, 16'h0010, 16'h0001};
        logic [15:0] s_res [4] = '{16'h0002, 16'hFFFF, 16'h1234, 16'h0001};
        logic [2:0]  s_flg [4] = '{3'b100, 3'b001, 3'b000, 3'b100};
        for (int i = 0; i < 4; i++) begin
            drive_op(s_op[i], s_a[i], s_b[i], 1'b1, 1'b1);
            step();
            tests_run++;
            if (obs0 !== {s_res[i], 1'b1, s_flg[i]}) begin
                tests_failed++;
                $display("FAIL shift_%0d got %h want %h", i, obs0, {s_res[i], 1'b1, s_flg[i]});
            end
        end
    endtask

    task automatic test_misc_ops();
        logic [3:0]  m_op  [10] = '{ALU_INC, ALU_DEC, ALU_NOT, ALU_AND, ALU_OR,
                                    ALU_XOR, ALU_PASS_B, ALU_ADD, ALU_SUB, ALU_PASS_A};
        logic [15:0] m_a   [10] = '{16'hFFFF, 16'h0000, 16'h00FF, 16'hF0F0, 16'h0F00,
                                    16'hFFFF, 16'h1111, 16'h7FFF, 16'h0005, 16'h0000};
        logic [15:0] m_b   [10] = '{16'h0000, 16'h0000, 16'h0000, 16'hFF00, 16'h00F0,
                                    16'hFFFF, 16'h8000, 16'h0001, 16'h0003, 16'hFFFF};
        logic [15:0] m_res [10] = '{16'h0000, 16'hFFFF, 16'hFF00, 16'hF000, 16'h0FF0,
                                    16'h0000, 16'h8000, 16'h8000, 16'h0002, 16'h0000};
        logic [2:0]  m_flg [10] = '{3'b110, 3'b101, 3'b001, 3'b001, 3'b000,
                                    3'b010, 3'b001, 3'b001, 3'b000, 3'b010};
        for (int i = 0; i < 10; i++) begin
            drive_op(m_op[i], m_a[i], m_b[i], 1'b1, 1'b1);
            step();
            tests_run++;
            if (obs0 !== {m_res[i], 1'b1, m_flg[i]}) begin
                tests_failed++;
                $display("FAIL op_%0d got %h want %h", i, obs0, {m_res[i], 1'b1, m_flg[i]});
            end
            if (i > 0) begin
                tests_run++;
                if (res_data[31:16] !== m_res[i-1]) begin
                    tests_failed++;
                    $display("FAIL shift_chain_%0d got %h want %h", i, res_data[31:16], m_res[i-1]);
                end
            end
        end
    endtask

    task automatic test_stall();
        drive_op(ALU_PASS_A, 16'h00AA, 16'h0000, 1'b0, 1'b1);
        step();
        drive_op(ALU_SUB, 16'h0000, 16'h0001, 1'b1, 1'b1);
        step();
        tests_run++;
        if (obs !== {16'h00AA, 16'hFFFF, 2'b11, 3'b101}) begin
            tests_failed++;
            $display("FAIL stall_setup got %h want %h", obs, {16'h00AA, 16'hFFFF, 2'b11, 3'b101});
        end
        stall = 1'b1;
        drive_op(ALU_ADD, 16'h0010, 16'h0020, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (obs !== {16'h00AA, 16'hFFFF, 2'b11, 3'b101}) begin
                tests_failed++;
                $display("FAIL stall_hold_%0d got %h want %h", i, obs, {16'h00AA, 16'hFFFF, 2'b11, 3'b101});
            end
        end
        stall = 1'b0;
        step();
        tests_run++;
        if (obs !== {16'hFFFF, 16'h0030, 2'b11, 3'b000}) begin
            tests_failed++;
            $display("FAIL stall_release got %h want %h", obs, {16'hFFFF, 16'h0030, 2'b11, 3'b000});
        end
    endtask

    task automatic test_flush();
        stall = 1'b1;
        flush = 1'b1;
        drive_op(ALU_ADD, 16'hFFFF, 16'h0001, 1'b1, 1'b1);
        step();
        tests_run++;
        if (obs !== {16'hFFFF, 16'h0030, 2'b00, 3'b000}) begin
            tests_failed++;
            $display("FAIL flush_clear got %h want %h", obs, {16'hFFFF, 16'h0030, 2'b00, 3'b000});
        end
        stall = 1'b0;
        flush = 1'b0;
        drive_op(ALU_PASS_A, 16'h0000, 16'h0000, 1'b0, 1'b0);
        step();
        tests_run++;
        if ({res_data[31:16], res_valid, carry_q, zero_q, neg_q} !== {16'h0030, 2'b00, 3'b000}) begin
            tests_failed++;
            $display("FAIL flush_no_op got %h want %h",
                     {res_data[31:16], res_valid, carry_q, zero_q, neg_q}, {16'h0030, 2'b00, 3'b000});
        end
        step();
        tests_run++;
        if (res_valid !== 2'b00) begin
            tests_failed++;
            $display("FAIL flush_drain got %b want %b", res_valid, 2'b00);
        end
    endtask

    task automatic test_flag_gate();
        drive_op(ALU_SUB, 16'h0000, 16'h0001, 1'b1, 1'b1);
        step();
        tests_run++;
        if (obs0 !== {16'hFFFF, 1'b1, 3'b101}) begin
            tests_failed++;
            $display("FAIL gate_setup got %h want %h", obs0, {16'hFFFF, 1'b1, 3'b101});
        end
        drive_op(ALU_ADD, 16'h0000, 16'h0000, 1'b0, 1'b1);
        step();
        tests_run++;
        if (obs !== {16'hFFFF, 16'h0000, 2'b11, 3'b101}) begin
            tests_failed++;
            $display("FAIL gate_hold got %h want %h", obs, {16'hFFFF, 16'h0000, 2'b11, 3'b101});
        end
        drive_op(4'd14, 16'h1234, 16'h5678, 1'b1, 1'b1);
        step();
        tests_run++;
        if (obs !== {16'h0000, 16'h0000, 2'b11, 3'b010}) begin
            tests_failed++;
            $display("FAIL illegal_op got %h want %h", obs, {16'h0000, 16'h0000, 2'b11, 3'b010});
        end
    endtask

    task automatic test_reset_midrun();
        drive_op(ALU_SUB, 16'h0000, 16'h0001, 1'b1, 1'b1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (obs !== 37'h0) begin
            tests_failed++;
            $display("FAIL reset_async got %h want %h", obs, 37'h0);
        end
        step();
        tests_run++;
        if (obs !== 37'h0) begin
            tests_failed++;
            $display("FAIL reset_held got %h want %h", obs, 37'h0);
        end
        rst_n = 1'b1;
        drive_op(ALU_ADD, 16'h0002, 16'h0003, 1'b1, 1'b1);
        step();
        tests_run++;
        if (obs !== {16'h0000, 16'h0005, 2'b01, 3'b000}) begin
            tests_failed++;
            $display("FAIL reset_release got %h want %h", obs, {16'h0000, 16'h0005, 2'b01, 3'b000});
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_immediate();
        test_shifts();
        test_misc_ops();
        test_stall();
        test_flush();
        test_flag_gate();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
